cfa_grad_ctrl: RTL and testbench



---
 rtl/cfa_grad_ctrl_pkg.sv | 20 ++
 rtl/grad_out_fifo.sv | 62 ++++++
 rtl/cfa_grad_ctrl.sv | 145 ++++++++++++++
 tb/tb_cfa_grad_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfa_grad_ctrl_pkg.sv
// Shared definitions for the CFA gradient controller: FSM encoding,
// window geometry and the gradient-width derivation.
package cfa_grad_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int WIN        = 5;
    localparam int WIN_HALF   = WIN / 2;
    localparam int GRAD_GUARD = 5;

    // Gradient sums over a 5x5 window need 5 guard bits above the pixel width.
    function automatic int grad_width(input int pixel_width);
        return pixel_width + GRAD_GUARD;
    endfunction

endpackage

// File: rtl/grad_out_fifo.sv
// Small first-word-fall-through FIFO holding gradient results with their
// window-centre coordinates; head entry is always visible on pop_data.
module grad_out_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [DW-1:0]   push_data,
    input  logic            pop,
    output logic [DW-1:0]   pop_data,
    output logic            valid,
    output logic [CNTW-1:0] count
);

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] cnt;
    logic            do_push;
    logic            do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop  = pop && (cnt != '0);
    // A push into a full FIFO is still legal when the head leaves in the same cycle.
    assign do_push = push && ((cnt != CNTW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNTW'(1);
                2'b01:   cnt <= cnt - CNTW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign valid    = (cnt != '0);
    assign count    = cnt;

endmodule

// File: rtl/cfa_grad_ctrl.sv
// Raster sequencer for the 5x5 CFA gradient datapath: tracks pixel position,
// samples gradients of complete windows and queues them with centre coordinates.
module cfa_grad_ctrl
    import cfa_grad_ctrl_pkg::*;
#(
    parameter int  pixelBitWidth = 12,
    parameter int  IMG_W         = 640,
    parameter int  IMG_H         = 480,
    parameter int  CW            = 10,
    parameter int  RW            = 9,
    localparam int GW            = grad_width(pixelBitWidth)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          shift_en,
    input  logic [GW-1:0] grad_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [GW-1:0] grad_out,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          busy,
    output logic          done,
    output state_t        state_dbg
);

    // Handshakes: a transfer happens in any cycle where valid and ready are both
    // high; pix_valid/out_valid never wait on ready, ready may depend on valid.

    localparam int DW = GW + RW + CW;

    state_t        state_q;
    state_t        state_d;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          sample_q;
    logic [RW-1:0] samp_row_q;
    logic [CW-1:0] samp_col_q;

    logic          accept;
    logic          last_pix;
    logic          win_done;
    logic          fifo_valid;
    logic [1:0]    fifo_count;
    logic          pop;
    logic [2:0]    occ;
    logic [DW-1:0] fifo_rd;

    assign last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    assign win_done = (row_q >= RW'(WIN - 1)) && (col_q >= CW'(WIN - 1));
    assign pop      = fifo_valid && out_ready;

    // Occupancy credits the head leaving this cycle so a streaming pipeline
    // with out_ready=1 never stalls; the pending sample still reserves a slot.
    assign occ       = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, sample_q};
    assign pix_ready = (state_q == RUN) && (occ < 3'd2);
    assign accept    = pix_valid && pix_ready;
    assign shift_en  = accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (accept && last_pix) state_d = DRAIN;
            end
            DRAIN: begin
                if (!sample_q && (fifo_count == 2'd0)) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= last_pix ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // The datapath's gradient for the window ending at the accepted pixel
    // is presented one cycle later, so the centre is carried alongside.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q   <= 1'b0;
            samp_row_q <= '0;
            samp_col_q <= '0;
        end else begin
            sample_q <= accept && win_done;
            if (accept && win_done) begin
                samp_row_q <= row_q - RW'(WIN_HALF);
                samp_col_q <= col_q - CW'(WIN_HALF);
            end
        end
    end

    grad_out_fifo #(
        .DW    (DW),
        .DEPTH (2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sample_q),
        .push_data ({grad_in, samp_row_q, samp_col_q}),
        .pop       (pop),
        .pop_data  (fifo_rd),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign out_valid = fifo_valid;
    assign grad_out  = fifo_rd[DW-1 -: GW];
    assign out_row   = fifo_rd[CW +: RW];
    assign out_col   = fifo_rd[CW-1:0];
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_cfa_grad_ctrl.sv
// Directed scoreboard bench for cfa_grad_ctrl on an 8x6 frame.
module tb_cfa_grad_ctrl;
    import cfa_grad_ctrl_pkg::*;

    localparam int PBW = 12;
    localparam int W   = 8;
    localparam int H   = 6;
    localparam int CW  = 10;
    localparam int RW  = 9;
    localparam int GW  = PBW + 5;
    localparam int EW  = GW + RW + CW;
    localparam logic [7:0] CENTRES [8] = '{8'h22, 8'h23, 8'h24, 8'h25,
                                           8'h32, 8'h33, 8'h34, 8'h35};

    logic          clk;
    logic          rst;
    logic          start;
    logic          pix_valid;
    logic          pix_ready;
    logic          shift_en;
    logic [GW-1:0] grad_in;
    logic          out_valid;
    logic          out_ready;
    logic [GW-1:0] grad_out;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          busy;
    logic          done;
    state_t        state_dbg;

    cfa_grad_ctrl #(
        .pixelBitWidth (PBW),
        .IMG_W         (W),
        .IMG_H         (H),
        .CW            (CW),
        .RW            (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .shift_en  (shift_en),
        .grad_in   (grad_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grad_out  (grad_out),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    int cyc = 0;
    int accepts, results, done_cnt;
    int first_acc_cyc, last_acc_cyc, win44_cyc, first_valid_cyc, last_pop_cyc, done_cyc;
    int m_row, m_col;
    logic          hold_prev;
    logic [EW-1:0] hold_val;
    logic [EW-1:0] e;
    logic [7:0]    c;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // grad_in follows 100 + cycle index; inputs change 1 time unit after posedge.
    initial begin
        grad_in = GW'(100);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            grad_in = GW'(100 + cyc);
        end
    end

    // ---------------- scoreboard: expected results pushed on acceptance ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("shift_en", shift_en, pix_valid & pix_ready);
            if (pix_valid && pix_ready) begin
                if (accepts == 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                accepts++;
                if (m_row >= 4 && m_col >= 4) begin
                    exp_q.push_back({GW'(100 + cyc + 1), RW'(m_row - 2), CW'(m_col - 2)});
                    if (m_row == 4 && m_col == 4) win44_cyc = cyc;
                end
                if (m_col == W - 1) begin
                    m_col = 0;
                    m_row++;
                end else begin
                    m_col++;
                end
            end
        end
    end

    // ---------------- monitor: pop and compare on output transfer ----------------
    always @(negedge clk) begin
        if (!rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_stable", {grad_out, out_row, out_col}, hold_val);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got row %0d col %0d with nothing expected", out_row, out_col);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {grad_out, out_row, out_col}, e);
                end
                if (results < 8) begin
                    c = CENTRES[results];
                    check("centre_row", out_row, c[7:4]);
                    check("centre_col", out_col, c[3:0]);
                end
                results++;
                last_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            hold_prev = out_valid && !out_ready;
            hold_val  = {grad_out, out_row, out_col};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_frame();
        m_row = 0;
        m_col = 0;
        accepts = 0;
        results = 0;
        done_cnt = 0;
        first_valid_cyc = -1;
        win44_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done_cnt, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame_end(input string tag);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_accepts"}, accepts, 48);
        check({tag, "_results"}, results, 8);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pix_ready"}, pix_ready, 1'b0);
        check({tag, "_shift_en"}, shift_en, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_grad_out"}, grad_out, '0);
        check({tag, "_out_row"}, out_row, '0);
        check({tag, "_out_col"}, out_col, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_state"}, state_dbg, IDLE);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;
        m_row = 0; m_col = 0; accepts = 0; results = 0; done_cnt = 0;
        first_valid_cyc = -1; win44_cyc = -1; hold_prev = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("post_reset_busy", busy, 1'b0);

        // Full frame, streaming.
        out_ready = 1'b1;
        pix_valid = 1'b1;
        start_frame();
        wait_done(300);
        pix_valid = 1'b0;
        check_frame_end("stream");
        check("stream_consecutive", last_acc_cyc - first_acc_cyc, 47);
        check("stream_latency", first_valid_cyc - win44_cyc, 2);
        check("stream_done_after_pop", done_cyc - last_pop_cyc, 1);

        // Backpressure from the first result onward.
        @(posedge clk); #1;
        out_ready = 1'b0;
        pix_valid = 1'b1;
        start_frame();
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("bp_first_valid", out_valid, 1'b1);
        repeat (6) @(negedge clk);
        check("bp_stalled_ready", pix_ready, 1'b0);
        check("bp_full_valid", out_valid, 1'b1);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_ready_returns", pix_ready, 1'b1);
        wait_done(300);
        pix_valid = 1'b0;
        check_frame_end("bp");

        // Reset in the middle of a frame.
        @(posedge clk); #1;
        out_ready = 1'b1;
        pix_valid = 1'b1;
        start_frame();
        n = 0;
        while (accepts < 30 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("mid_accepts", accepts, 30);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_start_ignored", busy, 1'b0);
        start_frame();
        wait_done(300);
        pix_valid = 1'b0;
        check_frame_end("refresh");

        // Random gaps with stray start pulses during RUN.
        start_frame();
        n = 0;
        while (done_cnt == 0 && n < 1000) begin
            @(posedge clk); #1;
            pix_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            start     = (n == 10 || n == 25);
            n++;
        end
        start = 1'b0;
        pix_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_frame_end("gaps");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
